// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 joystick link transmitter.
// The button bit indices follow the line order LS FEDCBAUDLR, where bit 0 (R) goes out first.
package joy_db15_pkg;

    localparam int BITS_PER_PLAYER_DEFAULT = 12;
    localparam int TIMEOUT_CYCLES_DEFAULT  = 4096;

    localparam int BIT_R     = 0;
    localparam int BIT_L     = 1;
    localparam int BIT_DOWN  = 2;
    localparam int BIT_UP    = 3;
    localparam int BIT_A     = 4;
    localparam int BIT_B     = 5;
    localparam int BIT_C     = 6;
    localparam int BIT_D     = 7;
    localparam int BIT_E     = 8;
    localparam int BIT_F     = 9;
    localparam int BIT_START = 10;
    localparam int BIT_LS    = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } joy_state_t;

    function automatic int frameBits(input int bitsPerPlayer);
        return 2 * bitsPerPlayer;
    endfunction

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe from the joystick reader.
// It also produces single-cycle rising and falling pulses from the synchronized level.
module sync_edge
    import joy_db15_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick link transmitter that emulates the 165-style PISO adapter clocked by the reader.
// Optional idle-clock watchdog: define JOY_DB15_TX_TIMEOUT_EN.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int BITS_PER_PLAYER = BITS_PER_PLAYER_DEFAULT,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BITS_PER_PLAYER-1:0] joystick1,
    input  logic [BITS_PER_PLAYER-1:0] joystick2,
    input  logic                       JOY_LOAD,
    input  logic                       JOY_CLK,
    output logic                       JOY_DATA,
    output logic                       frame_done,
    output logic                       timeout
);

    localparam int FRAME_BITS = frameBits(BITS_PER_PLAYER);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_BITS);

    if (BITS_PER_PLAYER < 1 || TIMEOUT_CYCLES < 2) begin : g_paramCheck
        $error("joy_db15_tx: BITS_PER_PLAYER must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    logic w_loadLevel;
    logic w_loadRise;
    logic w_loadFall;
    logic w_clkLevel;
    logic w_clkRise;
    logic w_clkFall;
    logic w_unusedEdges;

    sync_edge #(.RESET_VAL(1'b1)) u_loadSync (
        .clk     (clk),
        .reset   (reset),
        .i_async (JOY_LOAD),
        .o_level (w_loadLevel),
        .o_rise  (w_loadRise),
        .o_fall  (w_loadFall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_clkSync (
        .clk     (clk),
        .reset   (reset),
        .i_async (JOY_CLK),
        .o_level (w_clkLevel),
        .o_rise  (w_clkRise),
        .o_fall  (w_clkFall)
    );

    assign w_unusedEdges = &{w_loadRise, w_loadFall, w_clkLevel, w_clkFall};

    joy_state_t              r_state;
    logic [FRAME_BITS-1:0]   r_snap;
    logic [CNT_W-1:0]        r_count;
    logic                    r_data;
    logic                    r_done;

    joy_state_t              w_stateNext;
    logic [FRAME_BITS-1:0]   w_snapNext;
    logic [CNT_W-1:0]        w_countNext;
    logic                    w_dataNext;
    logic                    w_doneNext;

`ifdef JOY_DB15_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;
    logic [WD_W-1:0] w_wdogNext;
    logic            w_timeoutNext;
`endif

    // A low LOAD wins over everything, so a reader can restart a frame at any point.
    always_comb begin
        w_stateNext = r_state;
        w_snapNext  = r_snap;
        w_countNext = r_count;
        w_doneNext  = 1'b0;
`ifdef JOY_DB15_TX_TIMEOUT_EN
        w_wdogNext    = '0;
        w_timeoutNext = r_timeout;
`endif

        if (!w_loadLevel) begin
            w_stateNext = LOAD;
            w_snapNext  = {joystick2, joystick1};
            w_countNext = '0;
`ifdef JOY_DB15_TX_TIMEOUT_EN
            w_timeoutNext = 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    w_stateNext = IDLE;
                end
                LOAD: begin
                    w_stateNext = SHIFT;
                end
                SHIFT: begin
                    if (w_clkRise) begin
                        w_snapNext  = {1'b0, r_snap[FRAME_BITS-1:1]};
                        w_countNext = r_count + 1'b1;
                        if (w_countNext == LAST_COUNT) begin
                            w_doneNext  = 1'b1;
                            w_stateNext = IDLE;
                        end
                    end
`ifdef JOY_DB15_TX_TIMEOUT_EN
                    if (!(w_clkRise || w_clkFall)) begin
                        w_wdogNext = r_wdog + 1'b1;
                        if (w_wdogNext == WD_LIMIT) begin
                            w_timeoutNext = 1'b1;
                            w_stateNext   = IDLE;
                        end
                    end
`endif
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end

        w_dataNext = (w_stateNext == IDLE) ? 1'b1 : ~w_snapNext[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_count <= '0;
            r_data  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_snap  <= w_snapNext;
            r_count <= w_countNext;
            r_data  <= w_dataNext;
            r_done  <= w_doneNext;
        end
    end

`ifdef JOY_DB15_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog    <= w_wdogNext;
            r_timeout <= w_timeoutNext;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign JOY_DATA   = r_data;
    assign frame_done = r_done;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx that acts as a DB15 reader and checks every captured frame bit.
// Define JOY_DB15_TX_TIMEOUT_EN when compiling to exercise the watchdog with a 64-cycle limit.
module tb_joy_db15_tx;

`ifdef JOY_DB15_TX_TIMEOUT_EN
    localparam int TOUT = 64;
`else
    localparam int TOUT = 4096;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        JOY_LOAD;
    logic        JOY_CLK;
    logic        JOY_DATA;
    logic        frame_done;
    logic        timeout;

    int checks    = 0;
    int errors    = 0;
    int doneCount = 0;

    typedef struct {
        string       name;
        logic [11:0] j1;
        logic [11:0] j2;
        logic [23:0] expLine;
    } vec_t;

    vec_t vecs[5];

    joy_db15_tx #(
        .BITS_PER_PLAYER (12),
        .TIMEOUT_CYCLES  (TOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_CLK    (JOY_CLK),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) doneCount++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] j1, input logic [11:0] j2);
        joystick1 = j1;
        joystick2 = j2;
    endtask

    task automatic loadPulse();
        JOY_LOAD = 1'b0;
        tick(6);
        JOY_LOAD = 1'b1;
        tick(6);
    endtask

    // The reader samples the line, then gives one clock pulse, for each bit.
    task automatic shiftBits(input int n, output logic [31:0] line);
        line = '0;
        for (int i = 0; i < n; i++) begin
            line[i] = JOY_DATA;
            JOY_CLK = 1'b1;
            tick(5);
            JOY_CLK = 1'b0;
            tick(5);
        end
    endtask

    initial begin
        logic [31:0] line;
        int          doneBefore;

        vecs[0] = '{"p1R_p2LS", 12'h001, 12'h800, 24'h7FFFFE};
        vecs[1] = '{"none",     12'h000, 12'h000, 24'hFFFFFF};
        vecs[2] = '{"all",      12'hFFF, 12'hFFF, 24'h000000};
        vecs[3] = '{"alt",      12'hA5A, 12'h3C3, 24'hC3C5A5};
        vecs[4] = '{"mixed",    12'h123, 12'h456, 24'hBA9EDC};

        reset    = 1'b1;
        JOY_LOAD = 1'b1;
        JOY_CLK  = 1'b0;
        applyStimulus(12'h000, 12'h000);
        tick(4);
        checkOutput("reset JOY_DATA", 32'(JOY_DATA), 32'h1);
        checkOutput("reset frame_done", 32'(frame_done), 32'h0);
        checkOutput("reset timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        tick(4);
        checkOutput("idle JOY_DATA", 32'(JOY_DATA), 32'h1);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].j1, vecs[v].j2);
            doneBefore = doneCount;
            loadPulse();
            shiftBits(24, line);
            tick(6);
            checkOutput($sformatf("%s frame", vecs[v].name), line, {8'h00, vecs[v].expLine});
            checkOutput($sformatf("%s done pulses", vecs[v].name), 32'(doneCount - doneBefore), 32'h1);
            checkOutput($sformatf("%s line idle", vecs[v].name), 32'(JOY_DATA), 32'h1);
        end

        // Inputs are transparent while LOAD is low and frozen once it is released.
        applyStimulus(12'h000, 12'h000);
        JOY_LOAD = 1'b0;
        tick(3);
        joystick1 = 12'h010;
        tick(5);
        JOY_LOAD = 1'b1;
        tick(6);
        joystick1 = 12'hFFF;
        shiftBits(24, line);
        tick(6);
        checkOutput("load transparency frame", line, 32'h00FFFFEF);

        // Restart after 10 bits: no pulse for the aborted frame, next frame intact.
        applyStimulus(12'h001, 12'h800);
        doneBefore = doneCount;
        loadPulse();
        shiftBits(10, line);
        checkOutput("abort partial bits", line, 32'h000003FE);
        applyStimulus(12'h123, 12'h456);
        JOY_LOAD = 1'b0;
        tick(6);
        checkOutput("restart load data", 32'(JOY_DATA), 32'h0);
        JOY_LOAD = 1'b1;
        tick(6);
        shiftBits(24, line);
        tick(6);
        checkOutput("restart frame", line, 32'h00BA9EDC);
        checkOutput("restart done pulses", 32'(doneCount - doneBefore), 32'h1);

        // Clocks beyond the frame end keep the line idle and raise no pulse.
        shiftBits(3, line);
        tick(6);
        checkOutput("extra clocks data", line, 32'h00000007);
        checkOutput("extra clocks done", 32'(doneCount - doneBefore), 32'h1);

        // Reset mid-frame returns the line to idle on the next cycle.
        applyStimulus(12'hFFF, 12'hFFF);
        doneBefore = doneCount;
        loadPulse();
        shiftBits(3, line);
        checkOutput("mid-frame data", 32'(JOY_DATA), 32'h0);
        reset = 1'b1;
        tick(1);
        checkOutput("reset mid-frame data", 32'(JOY_DATA), 32'h1);
        reset = 1'b0;
        tick(6);
        shiftBits(2, line);
        tick(6);
        checkOutput("post-reset idle clocks", line, 32'h00000003);
        checkOutput("post-reset done", 32'(doneCount - doneBefore), 32'h0);

        // Stop the reader clock after 5 bits.
        applyStimulus(12'hFFF, 12'hFFF);
        loadPulse();
        shiftBits(5, line);
        tick(40);
        checkOutput("stall early data", 32'(JOY_DATA), 32'h0);
        checkOutput("stall early timeout", 32'(timeout), 32'h0);
        tick(35);
`ifdef JOY_DB15_TX_TIMEOUT_EN
        checkOutput("watchdog timeout", 32'(timeout), 32'h1);
        checkOutput("watchdog data", 32'(JOY_DATA), 32'h1);
        JOY_LOAD = 1'b0;
        tick(6);
        checkOutput("load clears timeout", 32'(timeout), 32'h0);
        JOY_LOAD = 1'b1;
        tick(6);
`else
        checkOutput("stall late data", 32'(JOY_DATA), 32'h0);
        checkOutput("stall late timeout", 32'(timeout), 32'h0);
        loadPulse();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
